div16_seq: RTL and testbench

- Iterative restoring divider: unsigned 16-bit dividend / 16-bit divisor -> quotient + remainder, one quotient bit per clock.
- Multi-cycle execute-stage unit of the pipelined uniprocessor, the inverse counterpart to the adder/multiply path.
- Pipeline control stalls on busy and captures results on the done pulse.

---
 rtl/div16_seq_pkg.sv | 24 ++
 rtl/div16_seq_if.sv | 44 ++++
 rtl/div16_seq_div_step.sv | 43 ++++
 rtl/div16_seq.sv | 167 ++++++++++++++++
 tb/tb_div16_seq.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div16_seq_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg : shared definitions for the div16_seq iterative divider
//
// Contents
//   DIV_WIDTH     : default operand / result width
//   divState_t    : controller states (IDLE, CALC, FIXUP, DONE), 2 bits
//   DIV_ZERO_QUOT : quotient reported when the divisor is zero (all ones)
//
// FIXUP is only ever entered when the design is built with DIV_SIGNED_EN.
// ---------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } divState_t;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/div16_seq_if.sv
// ---------------------------------------------------------------------------
// div16_seq_if : request / result bundle between pipeline control and the
//                iterative divider
//
// Signals
//   start       : request, only honoured while the divider is IDLE or DONE
//   dividend    : numerator, captured on an accepted start
//   divisor     : denominator, captured on an accepted start
//   busy        : operation in flight, pipeline must stall
//   done        : one-cycle pulse, results valid this cycle
//   quotient    : registered quotient
//   remainder   : registered remainder
//   div_by_zero : divisor was zero for the last result
//
// Modports
//   master : pipeline control side (drives the request)
//   slave  : divider side (drives status and results)
// ---------------------------------------------------------------------------
interface div16_seq_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div16_seq_div_step.sv
// ---------------------------------------------------------------------------
// div_step : one combinational restoring-division iteration
//
// Ports
//   i_rem     : partial remainder R (WIDTH+1 bits)
//   i_quot    : quotient shift register Q, still holding the unused dividend
//               bits in its upper end
//   i_divisor : divisor magnitude
//   o_rem     : next partial remainder
//   o_quot    : next quotient shift register
// ---------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_quot,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_quot
);

    logic [WIDTH+1:0] w_remShift;
    logic [WIDTH+1:0] w_trial;

    // The trial subtraction is carried one bit wider than R so the borrow
    // lands in a bit of its own; a clear top bit means the divisor fitted.
    assign w_remShift = {i_rem, i_quot[WIDTH-1]};
    assign w_trial    = w_remShift - {2'b00, i_divisor};

    // Keep the difference and shift in a 1 when the subtraction fitted,
    // otherwise restore (keep the shifted value) and shift in a 0.
    always_comb begin
        o_rem  = w_remShift[WIDTH:0];
        o_quot = {i_quot[WIDTH-2:0], 1'b0};
        if (!w_trial[WIDTH+1]) begin
            o_rem     = w_trial[WIDTH:0];
            o_quot[0] = 1'b1;
        end
    end

endmodule

// File: rtl/div16_seq.sv
// ---------------------------------------------------------------------------
// div16_seq : iterative restoring divider, one quotient bit per clock
//
// Ports
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset (aborts any operation silently)
//   bus : div16_seq_if.slave (start/dividend/divisor in,
//         busy/done/quotient/remainder/div_by_zero out)
//
// Timing: start accepted at edge N, done high in the cycle after edge
// N+WIDTH+1. A zero divisor is reported after edge N+1 with
// quotient = all ones, remainder = dividend and div_by_zero set.
//
// Build option DIV_SIGNED_EN: operands are two's complement. Magnitudes are
// divided and an extra FIXUP cycle applies the signs (quotient negative when
// the operand signs differ, remainder follows the dividend).
// ---------------------------------------------------------------------------
module div16_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic       clk,
    input  logic       rst,
    div16_seq_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH);

    divState_t        r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH:0]   r_partRem;
    logic [WIDTH-1:0] r_quotSr;
    logic [WIDTH-1:0] r_divisor;
    logic             r_zero;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotOut;
    logic [WIDTH-1:0] r_remOut;
    logic             r_divZero;

    logic [WIDTH:0]   w_nextRem;
    logic [WIDTH-1:0] w_nextQuot;
    logic [WIDTH-1:0] w_dividendMag;
    logic [WIDTH-1:0] w_divisorMag;
    logic             w_needFixup;

`ifdef DIV_SIGNED_EN
    logic r_negQuot;
    logic r_negRem;

    // Only magnitudes go through the iteration; the signs are remembered at
    // accept and re-applied in FIXUP. The most negative value maps onto
    // itself, which is exactly its magnitude as an unsigned number.
    assign w_dividendMag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign w_divisorMag  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    assign w_needFixup   = !r_zero;
`else
    assign w_dividendMag = bus.dividend;
    assign w_divisorMag  = bus.divisor;
    assign w_needFixup   = 1'b0;
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem     (r_partRem),
        .i_quot    (r_quotSr),
        .i_divisor (r_divisor),
        .o_rem     (w_nextRem),
        .o_quot    (w_nextQuot)
    );

    // Controller, datapath registers and registered outputs.
    // A zero divisor skips the iterations: the working registers are loaded
    // with the final answer and the counter is preset to its last value, so
    // the result comes out through the normal CALC -> DONE path one edge
    // after accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_partRem <= '0;
            r_quotSr  <= '0;
            r_divisor <= '0;
            r_zero    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_quotOut <= '0;
            r_remOut  <= '0;
            r_divZero <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_negQuot <= 1'b0;
            r_negRem  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_state <= CALC;
                        r_busy  <= 1'b1;
                        if (bus.divisor == '0) begin
                            r_zero    <= 1'b1;
                            r_partRem <= {1'b0, bus.dividend};
                            r_quotSr  <= DIV_ZERO_QUOT[WIDTH-1:0];
                            r_count   <= LAST_COUNT;
                        end else begin
                            r_zero    <= 1'b0;
                            r_divZero <= 1'b0;
                            r_partRem <= '0;
                            r_quotSr  <= w_dividendMag;
                            r_divisor <= w_divisorMag;
                            r_count   <= '0;
                        end
`ifdef DIV_SIGNED_EN
                        r_negQuot <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        r_negRem  <= bus.dividend[WIDTH-1];
`endif
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CALC: begin
                    if (r_count == LAST_COUNT) begin
                        if (w_needFixup) begin
                            r_state <= FIXUP;
                        end else begin
                            r_state   <= DONE;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_quotOut <= r_quotSr;
                            r_remOut  <= r_partRem[WIDTH-1:0];
                            r_divZero <= r_zero;
                        end
                    end else begin
                        r_partRem <= w_nextRem;
                        r_quotSr  <= w_nextQuot;
                        r_count   <= r_count + 1'b1;
                    end
                end
`ifdef DIV_SIGNED_EN
                FIXUP: begin
                    r_state   <= DONE;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                    r_quotOut <= r_negQuot ? -r_quotSr : r_quotSr;
                    r_remOut  <= r_negRem ? -r_partRem[WIDTH-1:0] : r_partRem[WIDTH-1:0];
                    r_divZero <= 1'b0;
                end
`endif
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quotOut;
    assign bus.remainder   = r_remOut;
    assign bus.div_by_zero = r_divZero;

endmodule

// File: tb/tb_div16_seq.sv
// ---------------------------------------------------------------------------
// tb_div16_seq : self-checking bench for div16_seq
//
// Table of hand-picked operand pairs (issued back to back, start held during
// DONE), hand sequences for reset abort and operand/start activity during
// CALC, then a random regression. Expected results go into a scoreboard
// queue when a request is driven and are compared when done pulses.
// Build with DIV_SIGNED_EN to exercise the signed variant.
// ---------------------------------------------------------------------------
module tb_div16_seq;
    import div_pkg::*;

    typedef struct {
        logic [15:0] dvd;
        logic [15:0] dvs;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
    } vec_t;

    typedef struct {
        logic [15:0] dvd;
        logic [15:0] dvs;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        bit          chkInv;
    } exp_t;

    logic   clk;
    logic   rst;
    int     errors;
    int     checks;
    int     doneCount;
    exp_t   expQ[$];
    vec_t   tableVec[$];

    div16_seq_if #(.WIDTH(16)) bus ();

    div16_seq #(
        .WIDTH (16),
        .CNT_W (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global watchdog so a stuck design still produces a verdict.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached before end of test");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: native language division on the bench side.
    function automatic exp_t model(input logic [15:0] dvd, input logic [15:0] dvs);
        exp_t e;
        e.dvd    = dvd;
        e.dvs    = dvs;
        e.chkInv = 1'b0;
        if (dvs == 16'd0) begin
            e.q  = DIV_ZERO_QUOT;
            e.r  = dvd;
            e.dz = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            int a;
            int b;
            a   = int'($signed(dvd));
            b   = int'($signed(dvs));
            e.q = 16'(a / b);
            e.r = 16'(a % b);
`else
            e.q      = dvd / dvs;
            e.r      = dvd % dvs;
            e.chkInv = 1'b1;
`endif
            e.dz = 1'b0;
        end
        return e;
    endfunction

    function automatic int expLatOf(input logic [15:0] dvs);
        if (dvs == 16'd0) return 1;
`ifdef DIV_SIGNED_EN
        return 18;
`else
        return 17;
`endif
    endfunction

    function automatic exp_t fromVec(input vec_t v);
        exp_t e;
        e.dvd    = v.dvd;
        e.dvs    = v.dvs;
        e.q      = v.q;
        e.r      = v.r;
        e.dz     = v.dz;
        e.chkInv = 1'b0;
        return e;
    endfunction

    // Drive one request for one edge (called #1 after a rising edge while the
    // divider is IDLE or DONE) and queue its expected result.
    task automatic applyStimulus(input exp_t e);
        bus.start    = 1'b1;
        bus.dividend = e.dvd;
        bus.divisor  = e.dvs;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Count edges from the accept edge until done, checking busy on the way.
    task automatic waitDone(input int expLat, input int startLat);
        int lat;
        bit busyOk;
        lat    = startLat;
        busyOk = 1'b1;
        while (bus.done !== 1'b1 && lat < expLat + 20) begin
            if (bus.busy !== 1'b1) busyOk = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("done_latency", 32'(lat), 32'(expLat));
        checkOutput("busy_in_flight", 32'(busyOk), 32'd1);
        checkOutput("busy_at_done", 32'(bus.busy), 32'd0);
    endtask

    // Scoreboard side: every done pulse must match the oldest pending request.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done === 1'b1) begin
            doneCount++;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1 with q=0x%0h, expected no pending request",
                         bus.quotient);
            end else begin
                e = expQ.pop_front();
                checkOutput($sformatf("quotient %0h/%0h", e.dvd, e.dvs), 32'(bus.quotient), 32'(e.q));
                checkOutput($sformatf("remainder %0h/%0h", e.dvd, e.dvs), 32'(bus.remainder), 32'(e.r));
                checkOutput($sformatf("div_by_zero %0h/%0h", e.dvd, e.dvs), 32'(bus.div_by_zero), 32'(e.dz));
                if (e.chkInv) begin
                    checkOutput($sformatf("invariant %0h/%0h", e.dvd, e.dvs),
                                32'(bus.quotient) * 32'(e.dvs) + 32'(bus.remainder), 32'(e.dvd));
                    checkOutput($sformatf("rem_lt_div %0h/%0h", e.dvd, e.dvs),
                                32'(bus.remainder < e.dvs), 32'd1);
                end
            end
        end
    end

    initial begin
        exp_t e;
        int   doneBefore;
        errors       = 0;
        checks       = 0;
        doneCount    = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

`ifdef DIV_SIGNED_EN
        tableVec.push_back('{16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0});
        tableVec.push_back('{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0});
        tableVec.push_back('{16'd100,  16'd7,    16'd14,   16'd2,    1'b0});
        tableVec.push_back('{16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0});
        tableVec.push_back('{16'hFFF9, 16'hFFFE, 16'h0003, 16'hFFFF, 1'b0});
        tableVec.push_back('{16'h00AB, 16'h0000, 16'hFFFF, 16'h00AB, 1'b1});
        tableVec.push_back('{16'd10,   16'd3,    16'd3,    16'd1,    1'b0});
        tableVec.push_back('{16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b1});
        tableVec.push_back('{16'h7FFF, 16'h0001, 16'h7FFF, 16'h0000, 1'b0});
`else
        tableVec.push_back('{16'd100,  16'd7,    16'd14,   16'd2,    1'b0});
        tableVec.push_back('{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0});
        tableVec.push_back('{16'h1234, 16'h1234, 16'h0001, 16'h0000, 1'b0});
        tableVec.push_back('{16'h00AB, 16'h0000, 16'hFFFF, 16'h00AB, 1'b1});
        tableVec.push_back('{16'd10,   16'd3,    16'd3,    16'd1,    1'b0});
        tableVec.push_back('{16'd0,    16'd5,    16'd0,    16'd0,    1'b0});
        tableVec.push_back('{16'd5,    16'hFFFF, 16'd0,    16'd5,    1'b0});
        tableVec.push_back('{16'hFFFF, 16'hFFFF, 16'd1,    16'd0,    1'b0});
        tableVec.push_back('{16'h8000, 16'd3,    16'h2AAA, 16'd2,    1'b0});
`endif

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_quotient", 32'(bus.quotient), 32'd0);
        checkOutput("reset_remainder", 32'(bus.remainder), 32'd0);
        checkOutput("reset_div_by_zero", 32'(bus.div_by_zero), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table vectors, each issued while the previous one sits in DONE.
        for (int i = 0; i < tableVec.size(); i++) begin
            applyStimulus(fromVec(tableVec[i]));
            waitDone(expLatOf(tableVec[i].dvs), 0);
        end
        @(posedge clk);
        #1;

        // Reset part way through a calculation: no done, outputs cleared.
        doneBefore = doneCount;
        e = model(16'd500, 16'd3);
        applyStimulus(e);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_done", 32'(bus.done), 32'd0);
        checkOutput("abort_quotient", 32'(bus.quotient), 32'd0);
        checkOutput("abort_remainder", 32'(bus.remainder), 32'd0);
        checkOutput("abort_div_by_zero", 32'(bus.div_by_zero), 32'd0);
        rst = 1'b0;
        expQ.delete();
        repeat (25) @(posedge clk);
        #1;
        checkOutput("abort_no_done", 32'(doneCount - doneBefore), 32'd0);
        e = fromVec('{16'd9, 16'd4, 16'd2, 16'd1, 1'b0});
        applyStimulus(e);
        waitDone(expLatOf(16'd4), 0);
        @(posedge clk);
        #1;

        // Start toggling and operand changes while calculating are ignored.
        doneBefore = doneCount;
        e = fromVec('{16'd1000, 16'd10, 16'd100, 16'd0, 1'b0});
        applyStimulus(e);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            bus.start    = ~bus.start;
            bus.dividend = 16'($urandom);
            bus.divisor  = 16'($urandom);
        end
        bus.start = 1'b0;
        waitDone(expLatOf(16'd10), 8);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("single_done_pulse", 32'(doneCount - doneBefore), 32'd1);

        // Random regression, back to back.
        for (int i = 0; i < 2000; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            a = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       b = 16'd0;
                1, 2:    b = 16'($urandom_range(1, 255));
                default: b = 16'($urandom);
            endcase
            applyStimulus(model(a, b));
            waitDone(expLatOf(b), 0);
        end
        repeat (3) @(posedge clk);
        #1;

        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
